// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle main control FSM.
// State enum, datapath mux codes, default opcodes and the packed control-word struct.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch
  } state_t;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam int unsigned DefOpRtype  = 0;
  localparam int unsigned DefOpLoad   = 1;
  localparam int unsigned DefOpStore  = 2;
  localparam int unsigned DefOpBranch = 3;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       branch;
    logic       pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational output decoder: current state plus mem_ready -> datapath control word.
// Memory-completion strobes (IRWrite, PCWrite, store instr_done) are qualified by memReady.
module multicycle_ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t state,
  input  logic   memReady,
  input  logic   opIllegal,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SrcBFour;
        ctrl.aluOp   = AluAdd;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      StDecode: begin
        // Precompute branch target in ALUOut while the opcode is decoded.
        ctrl.aluSrcB   = SrcBImmSh;
        ctrl.aluOp     = AluAdd;
        ctrl.illegalOp = opIllegal;
        ctrl.instrDone = opIllegal;
      end
      StMemAdr: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SrcBImm;
        ctrl.aluOp   = AluAdd;
      end
      StMemRd: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      StMemWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memtoReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      StMemWr: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = memReady;
      end
      StExec: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SrcBRegB;
        ctrl.aluOp   = AluFunct;
      end
      StAluWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      StBranch: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluSrcB   = SrcBRegB;
        ctrl.aluOp     = AluSub;
        ctrl.branch    = 1'b1;
        ctrl.pcSource  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/writeback over a shared datapath.
// Holds the state register and next-state logic; outputs come from the decoder, forced 0 in reset.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 2,
  parameter int unsigned OP_RTYPE  = DefOpRtype,
  parameter int unsigned OP_LOAD   = DefOpLoad,
  parameter int unsigned OP_STORE  = DefOpStore,
  parameter int unsigned OP_BRANCH = DefOpBranch
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Branch,
  output logic            PCSource,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            instr_done,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] OpRtype  = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OpLoad   = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] OpStore  = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] OpBranch = OP_W'(OP_BRANCH);

  if (OP_W < 2) begin : gen_bad_width
    $error("multicycle_control: OP_W must be at least 2");
  end
  if (OpRtype == OpLoad || OpRtype == OpStore || OpRtype == OpBranch ||
      OpLoad == OpStore || OpLoad == OpBranch || OpStore == OpBranch) begin : gen_bad_ops
    $error("multicycle_control: opcode parameters must be distinct");
  end

  state_t stateQ, stateD;
  ctrl_t  ctrl, ctrlOut;
  logic   isRtype, isLoad, isStore, isBranch, opIllegal;

  assign isRtype   = (op == OpRtype);
  assign isLoad    = (op == OpLoad);
  assign isStore   = (op == OpStore);
  assign isBranch  = (op == OpBranch);
  assign opIllegal = ~(isRtype | isLoad | isStore | isBranch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StFetch:  if (mem_ready) stateD = StDecode;
      StDecode: begin
        if (isRtype)                stateD = StExec;
        else if (isLoad || isStore) stateD = StMemAdr;
        else if (isBranch)          stateD = StBranch;
        else                        stateD = StFetch;
      end
      // The instruction register is stable, so op can be re-read to split load/store.
      StMemAdr: begin
        if (isLoad)       stateD = StMemRd;
        else if (isStore) stateD = StMemWr;
        else              stateD = StFetch;
      end
      StMemRd:  if (mem_ready) stateD = StMemWb;
      StMemWb:  stateD = StFetch;
      StMemWr:  if (mem_ready) stateD = StFetch;
      StExec:   stateD = StAluWb;
      StAluWb:  stateD = StFetch;
      StBranch: stateD = StFetch;
      default:  stateD = StFetch;
    endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (stateQ),
    .memReady  (mem_ready),
    .opIllegal (opIllegal),
    .ctrl      (ctrl)
  );

  // Gate combinationally so an abandoned instruction cannot strobe writes during reset.
  assign ctrlOut = reset ? '0 : ctrl;

  assign MemRead    = ctrlOut.memRead;
  assign MemWrite   = ctrlOut.memWrite;
  assign IorD       = ctrlOut.iorD;
  assign IRWrite    = ctrlOut.irWrite;
  assign PCWrite    = ctrlOut.pcWrite;
  assign Branch     = ctrlOut.branch;
  assign PCSource   = ctrlOut.pcSource;
  assign ALUSrcA    = ctrlOut.aluSrcA;
  assign ALUSrcB    = ctrlOut.aluSrcB;
  assign ALUOp      = ctrlOut.aluOp;
  assign RegDst     = ctrlOut.regDst;
  assign MemtoReg   = ctrlOut.memtoReg;
  assign RegWrite   = ctrlOut.regWrite;
  assign instr_done = ctrlOut.instrDone;
  assign illegal_op = ctrlOut.illegalOp;

endmodule
